// File: rtl/serial_master_port.sv
// Serial bus master: frames a host request onto control, shifts write words out on wD, shifts read words in from rD.
// Frame starts the cycle after start; write stalls on ready/wr_valid, read capture pauses while ready is low.
module serial_master_port #(
    parameter int SLAVES     = 3,
    parameter int ADDR_DEPTH = 2000,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 256,
    parameter int TIMEOUT    = 64,
    localparam int SLAVEID    = $clog2(SLAVES),
    localparam int ADDR_WIDTH = $clog2(ADDR_DEPTH),
    localparam int LEN_W      = $clog2(MAX_BURST + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SLAVEID-1:0]    slave_id,
    input  logic                  rw,
    input  logic                  burst,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [LEN_W-1:0]      burst_len,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  control,
    output logic                  wD,
    output logic                  valid,
    output logic                  last,
    input  logic                  rD,
    input  logic                  ready
);
    localparam int F   = 3 + SLAVEID + 2 + ADDR_WIDTH;
    localparam int FCW = $clog2(F + 1);
    localparam int SCW = $clog2(DATA_WIDTH) + 1;
    localparam int TCW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, CTRL, W_WAIT, W_SHIFT, R_WAIT, R_SHIFT, FIN} state_t;

    state_t                state;
    logic [F-1:0]          frame_sh;
    logic [F-1:0]          frame_w;
    logic [FCW-1:0]        fcnt;
    logic [SCW-1:0]        bcnt;
    logic [TCW-1:0]        tcnt;
    logic [LEN_W-1:0]      nwords;
    logic [LEN_W-1:0]      widx;
    logic [DATA_WIDTH-1:0] sh;
    logic                  rw_q;
    logic                  ready_q;
    logic                  last_q;
    logic                  final_word;
    logic                  next_final;
    logic                  rd_first;
    logic                  bit_end;
    logic                  req_bad;

    assign frame_w    = {3'b111, slave_id, rw, burst, start_addr};
    assign final_word = (widx == nwords - LEN_W'(1));
    assign next_final = (widx + LEN_W'(1) == nwords - LEN_W'(1));
    assign bit_end    = (bcnt == SCW'(DATA_WIDTH - 1));
    assign rd_first   = (state == R_WAIT) && ready && !ready_q;
    assign req_bad    = (32'(start_addr) >= 32'(ADDR_DEPTH)) ||
                        (burst && (32'(burst_len) > 32'(MAX_BURST)));

    // Acceptance is only offered when the word will actually be loaded this edge.
    assign wr_ready = wr_valid && (((state == W_WAIT) && ready) ||
                                   ((state == W_SHIFT) && bit_end && !final_word));
    // The first read bit is captured in R_WAIT, before the registered flag can rise.
    assign last     = last_q || (rd_first && final_word);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            frame_sh <= '0;
            fcnt     <= '0;
            bcnt     <= '0;
            tcnt     <= '0;
            nwords   <= '0;
            widx     <= '0;
            sh       <= '0;
            rw_q     <= 1'b0;
            ready_q  <= 1'b0;
            last_q   <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            control  <= 1'b0;
            wD       <= 1'b0;
            valid    <= 1'b0;
        end else begin
            ready_q  <= ready;
            done     <= 1'b0;
            err      <= 1'b0;
            rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (req_bad) begin
                            err <= 1'b1;
                        end else begin
                            state    <= CTRL;
                            busy     <= 1'b1;
                            control  <= frame_w[F-1];
                            frame_sh <= frame_w << 1;
                            fcnt     <= '0;
                            rw_q     <= rw;
                            nwords   <= (burst && burst_len != '0) ? burst_len : LEN_W'(1);
                            widx     <= '0;
                        end
                    end
                end
                CTRL: begin
                    if (fcnt == FCW'(F - 1)) begin
                        control <= 1'b0;
                        tcnt    <= '0;
                        state   <= rw_q ? W_WAIT : R_WAIT;
                    end else begin
                        control  <= frame_sh[F-1];
                        frame_sh <= frame_sh << 1;
                        fcnt     <= fcnt + FCW'(1);
                    end
                end
                W_WAIT: begin
                    if (ready) begin
                        tcnt <= '0;
                        if (wr_valid) begin
                            sh     <= wr_data << 1;
                            wD     <= wr_data[DATA_WIDTH-1];
                            valid  <= 1'b1;
                            last_q <= final_word;
                            bcnt   <= '0;
                            state  <= W_SHIFT;
                        end
                    end else if (tcnt == TCW'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + TCW'(1);
                    end
                end
                W_SHIFT: begin
                    if (bit_end) begin
                        if (final_word) begin
                            valid  <= 1'b0;
                            wD     <= 1'b0;
                            last_q <= 1'b0;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            state  <= FIN;
                        end else begin
                            widx <= widx + LEN_W'(1);
                            if (wr_valid) begin
                                sh     <= wr_data << 1;
                                wD     <= wr_data[DATA_WIDTH-1];
                                last_q <= next_final;
                                bcnt   <= '0;
                            end else begin
                                valid  <= 1'b0;
                                wD     <= 1'b0;
                                last_q <= 1'b0;
                                tcnt   <= '0;
                                state  <= W_WAIT;
                            end
                        end
                    end else begin
                        wD   <= sh[DATA_WIDTH-1];
                        sh   <= sh << 1;
                        bcnt <= bcnt + SCW'(1);
                    end
                end
                R_WAIT: begin
                    if (ready) begin
                        tcnt <= '0;
                        if (!ready_q) begin
                            sh     <= {sh[DATA_WIDTH-2:0], rD};
                            bcnt   <= SCW'(1);
                            last_q <= final_word;
                            state  <= R_SHIFT;
                        end
                    end else if (tcnt == TCW'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + TCW'(1);
                    end
                end
                R_SHIFT: begin
                    if (ready) begin
                        if (bit_end) begin
                            rd_data  <= {sh[DATA_WIDTH-2:0], rD};
                            rd_valid <= 1'b1;
                            bcnt     <= '0;
                            if (final_word) begin
                                last_q <= 1'b0;
                                done   <= 1'b1;
                                busy   <= 1'b0;
                                state  <= FIN;
                            end else begin
                                widx   <= widx + LEN_W'(1);
                                last_q <= next_final;
                            end
                        end else begin
                            sh   <= {sh[DATA_WIDTH-2:0], rD};
                            bcnt <= bcnt + SCW'(1);
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_master_port.sv
// Directed/randomised bench for serial_master_port with a stream-level reference model.
module tb_serial_master_port;
    localparam int DW = 32;
    localparam int AW = 11;
    localparam int LW = 9;
    localparam int SW = 2;
    localparam int F  = 18;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst, start, rw, burst, wr_valid, rD, ready;
    logic [SW-1:0] slave_id;
    logic [AW-1:0] start_addr;
    logic [LW-1:0] burst_len;
    logic [DW-1:0] wr_data;
    logic          wr_ready, rd_valid, busy, done, err, control, wD, valid, last;
    logic [DW-1:0] rd_data;

    always #5 clk = ~clk;

    serial_master_port dut (
        .clk(clk), .rst(rst), .start(start), .slave_id(slave_id), .rw(rw), .burst(burst),
        .start_addr(start_addr), .burst_len(burst_len), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
        .err(err), .control(control), .wD(wD), .valid(valid), .last(last), .rD(rD), .ready(ready)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic tr_ctrl[$], tr_val[$], tr_wd[$], tr_last[$], tr_busy[$], tr_done[$], tr_err[$], tr_rdv[$], tr_hs[$];
    logic [DW-1:0] rd_words[$];

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int cnt(logic q[$]);
        int c = 0;
        foreach (q[i]) if (q[i] === 1'b1) c++;
        return c;
    endfunction

    function automatic int first_idx(logic q[$]);
        foreach (q[i]) if (q[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int last_idx(logic q[$]);
        int r = -1;
        foreach (q[i]) if (q[i] === 1'b1) r = i;
        return r;
    endfunction

    // i-th transmitted frame bit: 1,1,1, slave_id, rw, burst, start_addr (MSB first)
    function automatic logic frame_bit(int i, logic [SW-1:0] id, logic r, logic b, logic [AW-1:0] a);
        if (i < 3) return 1'b1;
        if (i < 3 + SW) return id[SW-1-(i-3)];
        if (i == 3 + SW) return r;
        if (i == 4 + SW) return b;
        return a[AW-1-(i-5-SW)];
    endfunction

    task automatic clear_tr();
        tr_ctrl.delete(); tr_val.delete(); tr_wd.delete(); tr_last.delete(); tr_busy.delete();
        tr_done.delete(); tr_err.delete(); tr_rdv.delete(); tr_hs.delete(); rd_words.delete();
    endtask

    task automatic smp();
        #1;
        tr_ctrl.push_back(control); tr_val.push_back(valid); tr_wd.push_back(wD);
        tr_last.push_back(last); tr_busy.push_back(busy); tr_done.push_back(done);
        tr_err.push_back(err); tr_rdv.push_back(rd_valid); tr_hs.push_back(wr_valid && wr_ready);
        if (rd_valid === 1'b1) rd_words.push_back(rd_data);
    endtask

    task automatic idle_in();
        start = 0; rw = 0; burst = 0; slave_id = '0; start_addr = '0; burst_len = '0;
        wr_valid = 0; wr_data = '0; ready = 0; rD = 0;
    endtask

    task automatic chk_frame(input string tag, input logic [SW-1:0] id, input logic r, input logic b,
                             input logic [AW-1:0] a);
        int bad = 0;
        foreach (tr_ctrl[i]) begin
            logic e;
            e = (i >= 1 && i <= F) ? frame_bit(i - 1, id, r, b, a) : 1'b0;
            if (tr_ctrl[i] !== e) bad++;
        end
        chk(tag, bad, 0);
    endtask

    task automatic run_write(input logic [SW-1:0] id, input logic [AW-1:0] a, input logic b,
                             input logic [LW-1:0] len, input int rdy_delay, input int gap, input bit poke,
                             input int mode, input logic [DW-1:0] base);
        logic [DW-1:0] wq[$];
        int n, k, low, fin_t, budget, nv, fv, lv, vi, bad_wd, bad_last, di;
        bit hs;
        n = (b && len != 0) ? int'(len) : 1;
        for (int i = 0; i < n; i++) wq.push_back(mode == 1 ? base + DW'(i) : DW'($urandom));
        clear_tr();
        @(negedge clk);
        idle_in(); start = 1; rw = 1; burst = b; slave_id = id; start_addr = a; burst_len = len;
        smp();
        k = 0; hs = 0; low = 0; fin_t = -1;
        budget = F + rdy_delay + n * (DW + gap + 4) + 20;
        for (int t = 1; t < budget; t++) begin
            @(negedge clk);
            start = 0;
            if (poke && t == F + 10) begin start = 1; rw = 0; slave_id = ~id; start_addr = '0; end
            if (hs) begin k++; if (gap > 0 && k == 1) low = DW + gap - 1; end
            ready = (t >= F + 1 + rdy_delay);
            if (low > 0) begin
                wr_valid = 0; low--;
            end else if (k < n) begin
                wr_valid = 1; wr_data = wq[k];
            end else begin
                wr_valid = 0; wr_data = '0;
            end
            smp();
            hs = wr_valid && wr_ready;
            if (done === 1'b1 && fin_t < 0) fin_t = t;
            if (fin_t >= 0 && t >= fin_t + 3) break;
        end
        chk("wr_completed_in_budget", fin_t >= 0, 1);
        nv = cnt(tr_val); fv = first_idx(tr_val); lv = last_idx(tr_val);
        chk("wr_valid_cycles", nv, n * DW);
        chk("wr_first_valid_cycle", fv, F + 2 + rdy_delay);
        chk("wr_gap_cycles", (lv - fv + 1) - nv, (gap > 0 && n > 1) ? gap : 0);
        vi = 0; bad_wd = 0; bad_last = 0;
        foreach (tr_val[i]) begin
            if (tr_val[i] === 1'b1) begin
                if (vi < n * DW && tr_wd[i] !== wq[vi / DW][DW - 1 - (vi % DW)]) bad_wd++;
                if (tr_last[i] !== (vi >= (n - 1) * DW)) bad_last++;
                vi++;
            end else begin
                if (tr_wd[i] !== 1'b0) bad_wd++;
                if (tr_last[i] !== 1'b0) bad_last++;
            end
        end
        chk("wr_wd_stream", bad_wd, 0);
        chk("wr_last_window", bad_last, 0);
        chk("wr_ready_pulses", cnt(tr_hs), n);
        chk("wr_done_count", cnt(tr_done), 1);
        di = first_idx(tr_done);
        chk("wr_done_cycle", di, lv + 1);
        if (di > 0) chk("wr_busy_low_at_done", tr_busy[di], 0);
        chk("wr_err_count", cnt(tr_err), 0);
        chk("wr_rd_valid_count", cnt(tr_rdv), 0);
        chk_frame("wr_control_frame", id, 1'b1, b, a);
    endtask

    task automatic run_read(input logic [SW-1:0] id, input logic [AW-1:0] a, input logic b,
                            input logic [LW-1:0] len, input int pre_wait, input int pause_div,
                            input int mode, input logic [DW-1:0] base);
        logic [DW-1:0] wq[$];
        int fb[$];
        int n, t, lerr, bad, di;
        n = (b && len != 0) ? int'(len) : 1;
        for (int i = 0; i < n; i++) wq.push_back(mode == 1 ? base : DW'($urandom));
        clear_tr();
        @(negedge clk);
        idle_in(); start = 1; rw = 0; burst = b; slave_id = id; start_addr = a; burst_len = len;
        smp();
        t = 0; lerr = 0;
        repeat (F + pre_wait) begin
            @(negedge clk); start = 0; ready = 0; rD = 1'($urandom); smp(); t++;
        end
        for (int w = 0; w < n; w++) begin
            for (int i = DW - 1; i >= 0; i--) begin
                if (!(w == 0 && i == DW - 1) && pause_div > 0 && $urandom_range(pause_div - 1) == 0) begin
                    repeat ($urandom_range(3, 1)) begin
                        @(negedge clk); ready = 0; rD = 1'($urandom); smp(); t++;
                    end
                end
                @(negedge clk); ready = 1; rD = wq[w][i]; smp(); t++;
                if (last !== (w == n - 1)) lerr++;
                if (i == 0) fb.push_back(t);
            end
        end
        repeat (5) begin
            @(negedge clk); ready = 0; rD = 0; smp(); t++;
        end
        chk("rd_word_count", rd_words.size(), n);
        if (rd_words.size() > 0) chk("rd_first_word", rd_words[0], wq[0]);
        bad = 0;
        foreach (rd_words[i]) if (i < n && rd_words[i] !== wq[i]) bad++;
        chk("rd_word_values", bad, 0);
        bad = 0;
        foreach (fb[j]) if (fb[j] + 1 >= tr_rdv.size() || tr_rdv[fb[j] + 1] !== 1'b1) bad++;
        chk("rd_valid_timing", bad, 0);
        chk("rd_last_during_capture", lerr, 0);
        chk("rd_done_count", cnt(tr_done), 1);
        di = first_idx(tr_done);
        chk("rd_done_cycle", di, fb[n - 1] + 1);
        if (di > 0) chk("rd_busy_low_at_done", tr_busy[di], 0);
        chk("rd_err_count", cnt(tr_err), 0);
        chk("rd_no_write_activity", cnt(tr_val) + cnt(tr_hs) + cnt(tr_wd), 0);
        chk_frame("rd_control_frame", id, 1'b0, b, a);
    endtask

    task automatic run_timeout(input logic r);
        int ei;
        clear_tr();
        @(negedge clk);
        idle_in(); start = 1; rw = r; slave_id = 2'd1; start_addr = AW'($urandom_range(1999));
        smp();
        repeat (F + TO + 6) begin
            @(negedge clk); start = 0; ready = 0; wr_valid = 1; wr_data = DW'($urandom); smp();
        end
        ei = first_idx(tr_err);
        chk("to_err_count", cnt(tr_err), 1);
        chk("to_err_cycle", ei, F + 1 + TO);
        if (ei > 0) begin
            chk("to_busy_low_at_err", tr_busy[ei], 0);
            chk("to_busy_high_before_err", tr_busy[ei - 1], 1);
        end
        chk("to_done_count", cnt(tr_done), 0);
        chk("to_no_data", cnt(tr_val) + cnt(tr_hs) + cnt(tr_rdv), 0);
    endtask

    task automatic run_reject(input logic [AW-1:0] a, input logic b, input logic [LW-1:0] len);
        clear_tr();
        @(negedge clk);
        idle_in(); start = 1; rw = 1; burst = b; slave_id = 2'd0; start_addr = a; burst_len = len;
        smp();
        repeat (6) begin
            @(negedge clk); start = 0; ready = 1; wr_valid = 1; smp();
        end
        chk("rej_err_cycle", first_idx(tr_err), 1);
        chk("rej_err_count", cnt(tr_err), 1);
        chk("rej_no_activity", cnt(tr_busy) + cnt(tr_ctrl) + cnt(tr_val) + cnt(tr_done), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        idle_in();
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", {control, wD, valid, last, wr_ready, rd_valid, done, err, busy}, 0);
        chk("reset_rd_data", rd_data, 0);
        @(negedge clk);
        rst = 0;

        run_reject(AW'(2000), 1'b0, '0);
        run_reject(AW'(17), 1'b1, LW'(257));
        run_write(2'd2, AW'(5), 1'b0, '0, 3, 0, 0, 1, 32'hDEADBEEF);
        run_write(2'd0, AW'(300), 1'b1, LW'(3), 0, 0, 0, 1, 32'h1);
        run_write(2'd1, AW'(42), 1'b1, LW'(3), 2, 5, 0, 0, '0);
        run_read(2'd1, AW'(16), 1'b0, '0, 4, 0, 1, 32'hA5A5A5A5);
        run_read(2'd2, AW'(1999), 1'b1, LW'(4), 63, 6, 0, '0);
        run_read(2'd0, AW'(0), 1'b1, LW'(0), 0, 0, 0, '0);
        run_write(2'd2, AW'(1999), 1'b0, LW'(7), 63, 0, 1, 0, '0);
        run_write(2'd1, AW'(8), 1'b1, LW'(0), 1, 0, 0, 0, '0);
        run_write(2'd0, AW'(1000), 1'b1, LW'(256), 0, 0, 0, 0, '0);
        run_timeout(1'b1);
        run_timeout(1'b0);

        // Abort mid-word: reset during word 1 of a 3-word burst write
        clear_tr();
        @(negedge clk);
        idle_in(); start = 1; rw = 1; burst = 1; burst_len = LW'(3); slave_id = 2'd2; start_addr = AW'(7);
        smp();
        repeat (F + 12) begin
            @(negedge clk); start = 0; ready = 1; wr_valid = 1; wr_data = DW'($urandom); smp();
        end
        chk("rst_mid_valid_before", tr_val[tr_val.size() - 1], 1);
        @(negedge clk); rst = 1; smp();
        @(negedge clk); rst = 0; smp();
        chk("rst_mid_outputs", {control, wD, valid, last, wr_ready, rd_valid, done, err, busy}, 0);
        chk("rst_mid_rd_data", rd_data, 0);
        clear_tr();
        repeat (80) begin
            @(negedge clk); ready = 1; wr_valid = 1; smp();
        end
        chk("rst_mid_quiet", cnt(tr_done) + cnt(tr_err) + cnt(tr_val) + cnt(tr_ctrl) + cnt(tr_busy), 0);
        run_write(2'd1, AW'(123), 1'b1, LW'(2), 0, 0, 0, 0, '0);

        for (int r = 0; r < 4; r++) begin
            if ($urandom_range(1) == 1)
                run_write(SW'($urandom_range(2)), AW'($urandom_range(1999)), 1'b1, LW'($urandom_range(5, 1)),
                          $urandom_range(10), $urandom_range(1) * $urandom_range(7, 1), 0, 0, '0);
            else
                run_read(SW'($urandom_range(2)), AW'($urandom_range(1999)), 1'b1, LW'($urandom_range(5, 1)),
                         $urandom_range(20), 5, 0, '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
